sti_dac_mb: RTL

- Parametrised successor serial-transmit / data-arrange block.
- Accepts a parallel word with a length, fill, bit-order and half-select mode, and serialises it on so_data/so_valid.
- Deserialises the same bit stream into PIX_W-bit pixels and writes them in checkerboard order into BANKS pairs of odd/even memories.
- Zero-fills the remaining image after the last word, then asserts oem_finish.

---
 rtl/sti_dac_mb.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sti_dac_mb.sv
// Serial-transmit and data-arrange block: serialises framed parallel words, then packs the
// bit stream into pixels written in checkerboard order across odd/even memory bank pairs.
module sti_dac_mb #(
   parameter int IN_W    = 16,
   parameter int PIX_W   = 8,
   parameter int BANKS   = 4,
   parameter int ADDR_W  = 5,
   parameter int ROW_PIX = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [IN_W-1:0]   pi_data,
   input  logic [1:0]        pi_length,
   input  logic              pi_fill,
   input  logic              pi_msb,
   input  logic              pi_low,
   input  logic              pi_end,
   output logic              busy,
   output logic              so_data,
   output logic              so_valid,
   output logic              oem_finish,
   output logic [PIX_W-1:0]  oem_dataout,
   output logic [ADDR_W-1:0] oem_addr,
   output logic [BANKS-1:0]  odd_wr,
   output logic [BANKS-1:0]  even_wr
);
   localparam int FW    = 2 * IN_W;
   localparam int HW    = IN_W / 2;
   localparam int LW    = $clog2(FW) + 1;
   localparam int TOTAL = BANKS * 2 * (2 ** ADDR_W);
   localparam int PC_W  = $clog2(TOTAL) + 1;
   localparam int PB_W  = (PIX_W > 1) ? $clog2(PIX_W) : 1;
   localparam int RB    = $clog2(ROW_PIX);

   typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

   state_t            state;
   logic [FW-1:0]     sreg;
   logic [LW-1:0]     len_r;
   logic [LW-1:0]     bcnt;
   logic              msb_r;
   logic              end_r;
   logic [PIX_W-1:0]  pix_sh;
   logic [PB_W-1:0]   pbit;
   logic [PC_W-1:0]   pcnt;

   logic [LW-1:0]     len;
   logic [FW-1:0]     frame;
   logic [FW-1:0]     frame_al;
   logic              first_bit;
   logic              at_total;
   logic              bit_in;
   logic              shift_en;
   logic              pix_done;
   logic              zero_pix;
   logic              wr_go;
   logic              parity;
   logic [PIX_W-1:0]  wr_pix;
   logic [BANKS-1:0]  bank_sel;

   // Frame is built right-aligned; for MSB-first it is left-aligned so both orders shift from an end.
   always_comb begin
      len   = LW'((int'(pi_length) + 1) * HW);
      frame = '0;
      case (pi_length)
         2'd0:    frame[HW-1:0] = pi_low ? pi_data[IN_W-1:HW] : pi_data[HW-1:0];
         2'd1:    frame[IN_W-1:0] = pi_data;
         default: frame = pi_fill ? (FW'(pi_data) << (len - LW'(IN_W))) : FW'(pi_data);
      endcase
      frame_al  = pi_msb ? (frame << (LW'(FW) - len)) : frame;
      first_bit = pi_msb ? frame_al[FW-1] : frame_al[0];
   end

   always_comb begin
      at_total = (pcnt == PC_W'(TOTAL));
      bit_in   = so_valid & so_data;
      shift_en = so_valid | ((state == FLUSH) && (pbit != '0));
      pix_done = shift_en && (pbit == PB_W'(PIX_W - 1));
      zero_pix = (state == FLUSH) && !so_valid && (pbit == '0);
      wr_go    = (pix_done | zero_pix) & !at_total;
      wr_pix   = zero_pix ? '0 : {pix_sh[PIX_W-2:0], bit_in};
      // Checkerboard: (row + col) parity reduces to one row bit xor one column bit.
      parity   = pcnt[RB] ^ pcnt[0];
      bank_sel = BANKS'(1) << (pcnt >> (ADDR_W + 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         so_data     <= 1'b0;
         so_valid    <= 1'b0;
         oem_finish  <= 1'b0;
         oem_dataout <= '0;
         oem_addr    <= '0;
         odd_wr      <= '0;
         even_wr     <= '0;
         pcnt        <= '0;
         bcnt        <= '0;
         pbit        <= '0;
         pix_sh      <= '0;
      end else begin
         odd_wr  <= '0;
         even_wr <= '0;
         if (wr_go) begin
            oem_dataout <= wr_pix;
            oem_addr    <= pcnt[ADDR_W:1];
            if (!parity) odd_wr  <= bank_sel;
            else         even_wr <= bank_sel;
            pcnt <= pcnt + 1'b1;
         end
         if (shift_en) begin
            pix_sh <= {pix_sh[PIX_W-2:0], bit_in};
            pbit   <= pix_done ? '0 : pbit + 1'b1;
         end
         // The serialiser keeps running in DONE so a word cut short by a full image still completes.
         if (so_valid) begin
            if (bcnt == len_r) begin
               so_valid <= 1'b0;
               so_data  <= 1'b0;
            end else begin
               so_data <= msb_r ? sreg[FW-1] : sreg[0];
               sreg    <= msb_r ? (sreg << 1) : (sreg >> 1);
               bcnt    <= bcnt + 1'b1;
            end
         end
         case (state)
            IDLE: begin
               if (at_total) begin
                  state      <= DONE;
                  oem_finish <= 1'b1;
               end else if (load) begin
                  sreg     <= pi_msb ? (frame_al << 1) : (frame_al >> 1);
                  so_data  <= first_bit;
                  so_valid <= 1'b1;
                  busy     <= 1'b1;
                  len_r    <= len;
                  bcnt     <= LW'(1);
                  msb_r    <= pi_msb;
                  end_r    <= pi_end;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (at_total) begin
                  state      <= DONE;
                  oem_finish <= 1'b1;
                  busy       <= (bcnt != len_r);
               end else if (bcnt == len_r) begin
                  state <= end_r ? FLUSH : IDLE;
                  busy  <= end_r;
               end
            end
            FLUSH: begin
               if (at_total) begin
                  state      <= DONE;
                  oem_finish <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            DONE: begin
               if (so_valid && (bcnt == len_r)) busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
